// File: rtl/edge_pulse_pkg.sv
// Shared definitions for the edge pulse generator: edge-select encodings
// and the rule deciding whether an accepted level change is a reportable edge.
package edge_pulse_pkg;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  // new_lvl is the level just accepted; the old level is its complement.
  function automatic logic edge_qualify(input mode_e m, input logic new_lvl);
    case (m)
      MODE_RISE: edge_qualify = new_lvl;
      MODE_FALL: edge_qualify = ~new_lvl;
      MODE_BOTH: edge_qualify = 1'b1;
      default:   edge_qualify = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_pulse_channel.sv
// One channel: synchroniser chain, debounce counter, and a retriggerable
// fixed-width pulse stretcher. pulse_next is exported for the shared any_pulse flop.
module edge_pulse_channel
  import edge_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_WIDTH     = 1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  data_in,
  input  mode_e mode,
  output logic  pulse,
  output logic  level_out,
  output logic  pulse_next
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int WW = $clog2(PULSE_WIDTH) + 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          db_cnt_q, db_cnt_d;
  logic [WW-1:0]          w_cnt_q, w_cnt_d;
  logic                   level_d;
  logic                   accept;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    db_cnt_d   = '0;
    level_d    = level_out;
    accept     = 1'b0;
    w_cnt_d    = w_cnt_q;
    pulse_next = pulse;
    if (s != level_out) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = s;
        accept  = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
    // A qualified edge reloads the width counter even mid-pulse, so back-to-back
    // events merge into one continuous pulse.
    if (accept && edge_qualify(mode, s)) begin
      pulse_next = 1'b1;
      w_cnt_d    = WW'(PULSE_WIDTH - 1);
    end else if (pulse) begin
      if (w_cnt_q == '0) pulse_next = 1'b0;
      else               w_cnt_d    = w_cnt_q - WW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      w_cnt_q   <= '0;
      level_out <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      sync_q[0] <= data_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      db_cnt_q  <= db_cnt_d;
      w_cnt_q   <= w_cnt_d;
      level_out <= level_d;
      pulse     <= pulse_next;
    end
  end

endmodule

// File: rtl/edge_pulse_generator.sv
// Multi-channel debounced edge detector: CHANNELS independent lanes sharing
// one edge-select mode, plus a registered OR of all pulses.
module edge_pulse_generator
  import edge_pulse_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_WIDTH     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] data_in,
  input  logic [1:0]          mode,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] level_out,
  output logic                any_pulse
);

  mode_e               mode_sel;
  logic [CHANNELS-1:0] pulse_next;

  assign mode_sel = mode_e'(mode);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_pulse_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .PULSE_WIDTH     (PULSE_WIDTH)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in[g]),
      .mode       (mode_sel),
      .pulse      (pulse[g]),
      .level_out  (level_out[g]),
      .pulse_next (pulse_next[g])
    );
  end

  // Built from next-state pulses so it lands on the same edge as pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_pulse <= 1'b0;
    else       any_pulse <= |pulse_next;
  end

endmodule

// File: tb/tb_edge_pulse_generator.sv
// Bench for edge_pulse_generator: table-driven scoreboard on a default-parameter
// instance, plus hand sequences for reset, retrigger and mode-change corners.
module tb_edge_pulse_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din, din2;
  logic [1:0] md, md2;
  logic [3:0] pulse, level_out, pulse2, level2;
  logic       any_pulse, any2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  edge_pulse_generator dut (
    .clk(clk), .reset(reset), .data_in(din), .mode(md),
    .pulse(pulse), .level_out(level_out), .any_pulse(any_pulse)
  );

  edge_pulse_generator #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .PULSE_WIDTH(8)) dut2 (
    .clk(clk), .reset(reset), .data_in(din2), .mode(md2),
    .pulse(pulse2), .level_out(level2), .any_pulse(any2)
  );

  typedef struct { int due; logic [3:0] lvl; logic [3:0] pls; } exp_t;
  typedef struct { logic [3:0] din; logic [1:0] mode; int hold; logic [3:0] lvl; logic [3:0] pls; } vec_t;

  exp_t       sbq[$];
  vec_t       tbl[14];
  logic [3:0] exp_lvl = '0;
  logic [3:0] exp_pls = '0;
  bit         sb_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Advance one edge, then compare the default instance against the scoreboard.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (sb_on) begin
      exp_pls = '0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        exp_t e = sbq.pop_front();
        exp_lvl = e.lvl;
        exp_pls = e.pls;
      end
      check("level", 32'(level_out), 32'(exp_lvl));
      check("pulse", 32'(pulse), 32'(exp_pls));
      check("any_pulse", 32'(any_pulse), 32'(|exp_pls));
    end
  endtask

  // Default latency: driven after edge cyc, visible after edge cyc+1+2+4-1.
  task automatic expect_at_latency(input logic [3:0] lvl, input logic [3:0] pls);
    exp_t e;
    e.due = cyc + 6;
    e.lvl = lvl;
    e.pls = pls;
    sbq.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b0001, 2'b00, 10, 4'b0001, 4'b0001}; // rise, mode rise
    tbl[1]  = '{4'b0000, 2'b00, 10, 4'b0000, 4'b0000}; // fall ignored
    tbl[2]  = '{4'b0010, 2'b00,  3, 4'b0000, 4'b0000}; // 3-cycle glitch
    tbl[3]  = '{4'b0000, 2'b00, 10, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0100, 2'b01, 10, 4'b0100, 4'b0000}; // rise in fall mode
    tbl[5]  = '{4'b0000, 2'b01, 10, 4'b0000, 4'b0100};
    tbl[6]  = '{4'b1000, 2'b10, 10, 4'b1000, 4'b1000}; // both
    tbl[7]  = '{4'b0000, 2'b10, 10, 4'b0000, 4'b1000};
    tbl[8]  = '{4'b1111, 2'b11, 10, 4'b1111, 4'b0000}; // disabled, level tracks
    tbl[9]  = '{4'b0000, 2'b01, 10, 4'b0000, 4'b1111}; // all fall together
    tbl[10] = '{4'b0101, 2'b10, 10, 4'b0101, 4'b0101};
    tbl[11] = '{4'b1010, 2'b10, 10, 4'b1010, 4'b1111};
    tbl[12] = '{4'b1000, 2'b00,  1, 4'b1010, 4'b0000}; // 1-cycle dip on ch1
    tbl[13] = '{4'b1010, 2'b00, 10, 4'b1010, 4'b0000};

    reset = 1'b1; din = '0; din2 = '0; md = 2'b00; md2 = 2'b00;
    #3;
    check("reset_level", 32'(level_out), 32'h0);
    check("reset_pulse", 32'(pulse), 32'h0);
    check("reset_any", 32'(any_pulse), 32'h0);
    check("reset_level2", 32'(level2), 32'h0);
    repeat (2) tick();
    reset = 1'b0;
    sb_on = 1'b1;

    foreach (tbl[i]) begin
      din = tbl[i].din;
      md  = tbl[i].mode;
      expect_at_latency(tbl[i].lvl, tbl[i].pls);
      repeat (tbl[i].hold) tick();
    end
    repeat (8) tick();

    // Reset mid-pulse, then input held high through release.
    din = 4'b0001; md = 2'b00;
    expect_at_latency(4'b0001, 4'b0001);
    repeat (6) tick();
    #3 reset = 1'b1;
    #1;
    check("rst_async_pulse", 32'(pulse), 32'h0);
    check("rst_async_level", 32'(level_out), 32'h0);
    check("rst_async_any", 32'(any_pulse), 32'h0);
    sb_on = 1'b0;
    sbq.delete();
    repeat (3) begin
      tick();
      check("rst_hold_level", 32'(level_out), 32'h0);
      check("rst_hold_pulse", 32'(pulse), 32'h0);
    end
    reset   = 1'b0;
    exp_lvl = '0;
    sb_on   = 1'b1;
    expect_at_latency(4'b0001, 4'b0001);
    repeat (10) tick();

    // Retrigger: ch2 toggles every 4 cycles, pulse must stay up continuously.
    md2 = 2'b10;
    for (int i = 0; i < 28; i++) begin
      int c;
      if (i % 4 == 0 && i < 16) din2[2] = ~din2[2];
      tick();
      c = i + 1;
      check("retrig_pulse", 32'(pulse2[2]), 32'(c >= 3 && c <= 22));
      check("retrig_any", 32'(any2), 32'(c >= 3 && c <= 22));
    end

    // Mode change mid-pulse must not truncate it; mode off still tracks level.
    for (int i = 0; i < 14; i++) begin
      int c;
      if (i == 0) begin din2[0] = 1'b1; md2 = 2'b00; end
      if (i == 4) begin din2[1] = 1'b1; md2 = 2'b11; end
      tick();
      c = i + 1;
      check("mode_keep_pulse", 32'(pulse2[0]), 32'(c >= 3 && c <= 10));
      check("off_no_pulse", 32'(pulse2[1]), 32'h0);
      check("off_level", 32'(level2[1]), 32'(c >= 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_pulse_generator.md
EDGE_PULSE_GENERATOR -- requirements
Module: edge_pulse_generator

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4: number of independent input channels, legal range 1..32.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: synchroniser flop depth per channel, minimum 1.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a new level must persist before it is accepted, minimum 1.
REQ-004 The block SHALL have parameter PULSE_WIDTH, default 1: output pulse length in cycles, minimum 1.
REQ-005 clk  input  1  the single clock, all state on its rising edge.
REQ-006 reset  input  1  reset, asynchronous and active-high.
REQ-007 data_in  input  CHANNELS  asynchronous level inputs, one bit per channel.
REQ-008 mode  input  2  global edge select: 00 rising, 01 falling, 10 both, 11 disabled.
REQ-009 pulse  output  CHANNELS  registered per-channel edge pulses.
REQ-010 level_out  output  CHANNELS  registered debounced level per channel.
REQ-011 any_pulse  output  1  registered OR of all pulse bits.

Function
REQ-012 Each channel SHALL pass data_in through SYNC_STAGES flops; the last stage is the synchronised level s.
REQ-013 Debounce per channel: if s equals level_out, the counter clears; otherwise it increments, and on the edge where it equals DEBOUNCE_CYCLES-1 the block loads level_out from s and clears the counter.
REQ-014 A single-cycle mismatch, or any mismatch shorter than DEBOUNCE_CYCLES, SHALL clear the counter on return and never change level_out.
REQ-015 An accepted level change is an edge event, qualified by the mode value sampled on the same clock edge: rising (0->1) for mode 00, falling (1->0) for mode 01, either for mode 10, none for mode 11.
REQ-016 A qualified event SHALL assert pulse on the same clock edge that updates level_out, holding it high for exactly PULSE_WIDTH cycles.
REQ-017 A qualified event during an active pulse SHALL restart the width counter, which extends the pulse by retriggering; the pulse does not drop between events.
REQ-018 Latency: for data_in stable before capture edge k, level_out and pulse SHALL change after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-019 A mode change SHALL NOT truncate or clear an active pulse; mode 11 SHALL still let level_out track the input.
REQ-020 any_pulse SHALL be the registered OR of the next-state pulse vector, so it is cycle-aligned with pulse.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce a pulse.

Reset
REQ-022 While reset is high, all synchroniser flops, level_out, the debounce counters, the width counters, pulse and any_pulse SHALL be 0, asynchronously.
REQ-023 An input held high through reset SHALL be treated as a 0->1 change after deassertion, producing a rising event at the REQ-018 latency.
REQ-024 Reset asserted mid-pulse or mid-debounce SHALL abort it immediately with no residual pulse after release.

Structure
REQ-025 A package edge_pulse_pkg SHALL hold the mode encodings (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_OFF) and the mode typedef.
REQ-026 Per-channel logic SHALL be a sub-module edge_pulse_channel, instantiated CHANNELS times by generate.
REQ-027 Counter widths SHALL be $clog2 of the parameter value plus 1, with no wrap-around reachable.

Verification (defaults unless stated)
REQ-028 Rise: mode 00, ch0 0->1 before edge 10 -> level_out[0] and pulse[0] high after edge 15, pulse[0] low after edge 16; no pulse on the later fall.
REQ-029 Glitch: ch1 high for 3 cycles, then low -> level_out[1] and pulse[1] stay 0 throughout.
REQ-030 Both and retrigger: PULSE_WIDTH=8, DEBOUNCE_CYCLES=1, mode 10, ch2 toggles every 4 cycles -> pulse[2] stays high continuously until 8 cycles after the last accepted toggle.
REQ-031 Mode and concurrency: mode 11, all channels rise -> level_out=4'hF, pulse=0; switch to 01, all fall together -> pulse=4'hF for 1 cycle, any_pulse aligned.
REQ-032 Reset: assert reset asynchronously mid-pulse -> pulse, level_out and any_pulse go 0 before the next clk edge; input held high through release -> rising pulse 6 edges after release.
